// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Issues one word-aligned fetch at a
// time from its own fetch address, buffers {pc, word} pairs in a small FIFO,
// and hands the head to decode. A redirect flushes the FIFO, reloads the fetch
// address and discards any response still in flight.
//
// Handshakes:
//   decode side: inst_valid/inst/inst_pc are valid together; a transfer
//   happens on a rising edge where inst_valid && inst_ready are both high.
//   inst_valid never depends on inst_ready.
//   memory side: mem_req/mem_addr are held stable until the edge where
//   mem_ack is sampled high; mem_data is only looked at on that edge.
//   Only one request is ever outstanding.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_addr,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  input  logic                     mem_ack,
  input  logic [DW-1:0]            mem_data,
  output logic                     inst_valid,
  output logic [DW-1:0]            inst,
  output logic [AW-1:0]            inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  // Fetch-side state
  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_fetch_pc;
  logic [AW-1:0]   w_fetch_pc_next;
  logic            r_mem_req;
  logic            w_mem_req_next;
  logic [AW-1:0]   r_mem_addr;
  logic [AW-1:0]   w_mem_addr_next;
  logic            w_push;

  // FIFO storage
  logic [AW-1:0]   r_pc_mem   [DEPTH];
  logic [DW-1:0]   r_word_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic            w_pop;
  logic [CW-1:0]   w_count_after_pop;
  logic            w_has_space;
  logic [AW-1:0]   w_redirect_pc;
  logic            w_unused;

  // The low address bits of a redirect target are dropped by design.
  assign w_redirect_pc     = {redirect_addr[AW-1:2], 2'b00};
  assign w_unused          = ^redirect_addr[1:0];

  assign w_pop             = (r_count != '0) && inst_ready;
  assign w_count_after_pop = r_count - {{PW{1'b0}}, w_pop};
  // A slot is reserved at issue time, so the eventual push can never overflow.
  assign w_has_space       = w_count_after_pop < CW'(DEPTH);

  // Next-state logic for the fetch FSM, fetch address and memory request.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_mem_req_next  = r_mem_req;
    w_mem_addr_next = r_mem_addr;
    w_push          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (redirect) begin
          w_fetch_pc_next = w_redirect_pc;
        end else if (w_has_space) begin
          w_mem_req_next  = 1'b1;
          w_mem_addr_next = r_fetch_pc;
          w_state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          w_mem_req_next = 1'b0;
          w_state_next   = S_IDLE;
          if (redirect) begin
            w_fetch_pc_next = w_redirect_pc;
          end else begin
            w_push          = 1'b1;
            w_fetch_pc_next = r_fetch_pc + AW'(4);
          end
        end else if (redirect) begin
          // Request stays up; its response will be thrown away.
          w_fetch_pc_next = w_redirect_pc;
          w_state_next    = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (redirect) begin
          w_fetch_pc_next = w_redirect_pc;
        end
        if (mem_ack) begin
          w_mem_req_next = 1'b0;
          w_state_next   = S_IDLE;
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_mem_req_next = 1'b0;
      end
    endcase
  end

  // Fetch FSM state, fetch address and memory request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_mem_req  <= w_mem_req_next;
      r_mem_addr <= w_mem_addr_next;
    end
  end

  // FIFO pointers, occupancy and storage; a redirect flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_word_mem[i] <= '0;
      end
    end else if (redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_tail]   <= r_mem_addr;
        r_word_mem[r_tail] <= mem_data;
        r_tail             <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign inst_valid = (r_count != '0);
  assign inst       = r_word_mem[r_head];
  assign inst_pc    = r_pc_mem[r_head];
  assign count      = r_count;
  assign dbg_state  = r_state;

endmodule
